// File: rtl/sigma_delta_decimator_pkg.sv
// Shared DSP definitions for the sigma-delta decimator: CIC order, internal
// width rule and the output saturation helper.
package sigma_delta_decimator_pkg;

  localparam int CIC_ORDER = 3;

  function automatic int cic_width(input int log2_osr);
    return CIC_ORDER * log2_osr + 1;
  endfunction

  // Clamp a signed value into the range of a bw-bit two's complement number.
  function automatic logic signed [63:0] sat_to_bw(input logic signed [63:0] v,
                                                   input int bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/sigma_delta_decimator_integrator.sv
// Single enabled W-bit wrap-around accumulator; one CIC integrator stage.
module sd_cic_integrator #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + in_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sigma_delta_decimator.sv
// Sigma-delta bitstream decimator: 3rd-order CIC, midpoint removal, scaling
// and saturation to signed BW-bit samples with a settling-gated valid strobe.
module sigma_delta_decimator
  import sigma_delta_decimator_pkg::*;
#(
  parameter int BW       = 16,
  parameter int LOG2_OSR = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 bit_i,
  output logic signed [BW-1:0] sample_o,
  output logic                 valid_o
);

  localparam int W     = cic_width(LOG2_OSR);
  localparam int GAINW = CIC_ORDER * LOG2_OSR;
  localparam int SHIFT = GAINW - BW;
  localparam logic [LOG2_OSR-1:0] CNT_LAST = '1;
  localparam logic signed [W:0] MIDPOINT = (W+1)'(1) << (GAINW - 1);

  if (GAINW < BW || LOG2_OSR > 8 || LOG2_OSR < 1) begin : g_param_check
    $error("sigma_delta_decimator: illegal BW / LOG2_OSR combination");
  end

  logic [W-1:0]          xIn;
  logic [W-1:0]          integ1;
  logic [W-1:0]          integ2;
  logic [W-1:0]          integ3;
  logic [LOG2_OSR-1:0]   cnt_q, cnt_d;
  logic                  decEdge;
  logic [W-1:0]          snap_q, snap_d;
  logic                  decStb_q, decStb_d;
  logic [W-1:0]          comb1_q, comb1_d;
  logic [W-1:0]          comb2_q, comb2_d;
  logic [W-1:0]          comb3_q, comb3_d;
  logic [W-1:0]          y1, y2, y3;
  logic signed [W:0]     centered;
  logic signed [W:0]     shifted;
  logic [1:0]            settle_q, settle_d;
  logic signed [BW-1:0]  sample_q, sample_d;
  logic                  valid_q, valid_d;

  assign xIn = {{(W-1){1'b0}}, bit_i};

  sd_cic_integrator #(.W(W)) u_int1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ena),
    .in_i  (xIn),
    .acc_o (integ1)
  );

  sd_cic_integrator #(.W(W)) u_int2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ena),
    .in_i  (integ1),
    .acc_o (integ2)
  );

  sd_cic_integrator #(.W(W)) u_int3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ena),
    .in_i  (integ2),
    .acc_o (integ3)
  );

  // The snapshot is taken as integ3+integ2, i.e. the value integ3 is about to
  // hold, so the comb sees exactly OSR integrated bits per frame.
  always_comb begin
    cnt_d    = ena ? cnt_q + 1'b1 : cnt_q;
    decEdge  = ena && (cnt_q == CNT_LAST);
    snap_d   = decEdge ? integ3 + integ2 : snap_q;
    decStb_d = decEdge;

    y1       = snap_q - comb1_q;
    y2       = y1 - comb2_q;
    y3       = y2 - comb3_q;
    centered = $signed({1'b0, y3}) - MIDPOINT;
    shifted  = centered >>> SHIFT;

    comb1_d  = comb1_q;
    comb2_d  = comb2_q;
    comb3_d  = comb3_q;
    sample_d = sample_q;
    settle_d = settle_q;
    valid_d  = 1'b0;
    if (decStb_q) begin
      comb1_d  = snap_q;
      comb2_d  = y1;
      comb3_d  = y2;
      sample_d = BW'(sat_to_bw(64'(shifted), BW));
      valid_d  = (settle_q == 2'd3);
      if (settle_q != 2'd3) begin
        settle_d = settle_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      snap_q   <= '0;
      decStb_q <= 1'b0;
      comb1_q  <= '0;
      comb2_q  <= '0;
      comb3_q  <= '0;
      settle_q <= 2'd0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      decStb_q <= decStb_d;
      comb1_q  <= comb1_d;
      comb2_q  <= comb2_d;
      comb3_q  <= comb3_d;
      settle_q <= settle_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Self-checking bench for sigma_delta_decimator: fixed patterns, enable gaps,
// mid-frame reset and random bitstreams against a closed-form CIC model.
module tb_sigma_delta_decimator;

  localparam int BW       = 16;
  localparam int LOG2_OSR = 6;
  localparam int OSR      = 1 << LOG2_OSR;
  localparam int GAINW    = 3 * LOG2_OSR;
  localparam int W        = GAINW + 1;
  localparam int SHIFT    = GAINW - BW;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 ena   = 1'b0;
  logic                 bit_i = 1'b0;
  logic signed [BW-1:0] sample_o;
  logic                 valid_o;

  int testsRun    = 0;
  int testsFailed = 0;

  bit                   bitsQ[$];
  longint               snapsQ[$];
  int                   combCount;
  bit                   pendingDec;
  logic signed [BW-1:0] expSample;
  logic                 expValid;

  always #5 clk = ~clk;

  sigma_delta_decimator #(
    .BW       (BW),
    .LOG2_OSR (LOG2_OSR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .bit_i    (bit_i),
    .sample_o (sample_o),
    .valid_o  (valid_o)
  );

  function automatic longint snap_at(input int k);
    if (k < 1) return 0;
    return snapsQ[k-1];
  endfunction

  task automatic model_reset();
    bitsQ.delete();
    snapsQ.delete();
    combCount  = 0;
    pendingDec = 1'b0;
    expSample  = '0;
    expValid   = 1'b0;
  endtask

  // Triple integration of N bits equals sum of x_j * C(N-1-j, 2); each output
  // is the third difference of successive snapshots, then centred and scaled.
  task automatic model_step(input bit b, input bit e);
    longint y3, s, snap, m, hi, lo;
    expValid = 1'b0;
    if (pendingDec) begin
      combCount++;
      y3 = snap_at(combCount) - 3 * snap_at(combCount - 1)
         + 3 * snap_at(combCount - 2) - snap_at(combCount - 3);
      y3 = y3 & ((longint'(1) <<< W) - 1);
      s  = y3 - (longint'(1) <<< (GAINW - 1));
      s  = s >>> SHIFT;
      hi = (longint'(1) <<< (BW - 1)) - 1;
      lo = -(longint'(1) <<< (BW - 1));
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
      expSample = BW'(s);
      expValid  = (combCount >= 4);
    end
    pendingDec = 1'b0;
    if (e) begin
      bitsQ.push_back(b);
      if (bitsQ.size() % OSR == 0) begin
        snap = 0;
        for (int j = 0; j < bitsQ.size(); j++) begin
          if (bitsQ[j]) begin
            m = longint'(bitsQ.size() - 1 - j);
            snap += m * (m - 1) / 2;
          end
        end
        snapsQ.push_back(snap);
        pendingDec = 1'b1;
      end
    end
  endtask

  task automatic drive_cycle(input bit b, input bit e);
    bit_i = b;
    ena   = e;
    @(posedge clk);
    model_step(b, e);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b0;
    bit_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if (sample_o !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_sample: got %0d expected 0", sample_o);
    end
    testsRun++;
    if (valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 1; c <= 20 + OSR + 2; c++) begin
      drive_cycle(1'b1, c > 20);
      testsRun++;
      if (valid_o !== expValid || sample_o !== expSample) begin
        testsFailed++;
        $display("[TB] FAIL reset_run cycle %0d: got valid=%b sample=%0d expected valid=%b sample=%0d",
                 c, valid_o, sample_o, expValid, expSample);
      end
    end
  endtask

  task automatic test_constant_ones();
    int firstValid = -1;
    int lastValid  = -1;
    apply_reset();
    for (int c = 1; c <= 7 * OSR; c++) begin
      drive_cycle(1'b1, 1'b1);
      testsRun++;
      if (valid_o !== expValid || sample_o !== expSample) begin
        testsFailed++;
        $display("[TB] FAIL ones cycle %0d: got valid=%b sample=%0d expected valid=%b sample=%0d",
                 c, valid_o, sample_o, expValid, expSample);
      end
      if (valid_o === 1'b1) begin
        testsRun++;
        if (sample_o !== 16'sd32767) begin
          testsFailed++;
          $display("[TB] FAIL ones_value: got %0d expected 32767", sample_o);
        end
        if (firstValid < 0) begin
          firstValid = c;
        end else begin
          testsRun++;
          if (c - lastValid != OSR) begin
            testsFailed++;
            $display("[TB] FAIL ones_period: got %0d expected %0d", c - lastValid, OSR);
          end
        end
        lastValid = c;
      end
    end
    testsRun++;
    if (firstValid != 4 * OSR + 1) begin
      testsFailed++;
      $display("[TB] FAIL ones_first_valid: got %0d expected %0d", firstValid, 4 * OSR + 1);
    end
  endtask

  task automatic test_patterns();
    logic signed [BW-1:0] expConst;
    bit b;
    int validsSeen;
    for (int p = 0; p < 3; p++) begin
      case (p)
        0:       expConst = -16'sd32768;
        1:       expConst = 16'sd0;
        default: expConst = 16'sd16384;
      endcase
      validsSeen = 0;
      apply_reset();
      for (int k = 0; k < 6 * OSR; k++) begin
        case (p)
          0:       b = 1'b0;
          1:       b = (k % 2 == 0);
          default: b = (k % 4 != 3);
        endcase
        drive_cycle(b, 1'b1);
        testsRun++;
        if (valid_o !== expValid || sample_o !== expSample) begin
          testsFailed++;
          $display("[TB] FAIL pattern%0d cycle %0d: got valid=%b sample=%0d expected valid=%b sample=%0d",
                   p, k, valid_o, sample_o, expValid, expSample);
        end
        if (valid_o === 1'b1) begin
          validsSeen++;
          testsRun++;
          if (sample_o !== expConst) begin
            testsFailed++;
            $display("[TB] FAIL pattern%0d_value: got %0d expected %0d", p, sample_o, expConst);
          end
        end
      end
      testsRun++;
      if (validsSeen != 2) begin
        testsFailed++;
        $display("[TB] FAIL pattern%0d_count: got %0d expected 2", p, validsSeen);
      end
    end
  endtask

  task automatic test_ena_gap();
    int firstValid = -1;
    int lastValid  = -1;
    bit e;
    apply_reset();
    for (int c = 1; c <= 5 * 2 * OSR + 4; c++) begin
      e = (c % 2 == 1);
      drive_cycle(e ? 1'b1 : 1'($urandom_range(0, 1)), e);
      testsRun++;
      if (valid_o !== expValid || sample_o !== expSample) begin
        testsFailed++;
        $display("[TB] FAIL gap cycle %0d: got valid=%b sample=%0d expected valid=%b sample=%0d",
                 c, valid_o, sample_o, expValid, expSample);
      end
      if (valid_o === 1'b1) begin
        testsRun++;
        if (sample_o !== 16'sd32767) begin
          testsFailed++;
          $display("[TB] FAIL gap_value: got %0d expected 32767", sample_o);
        end
        if (firstValid < 0) begin
          firstValid = c;
        end else begin
          testsRun++;
          if (c - lastValid != 2 * OSR) begin
            testsFailed++;
            $display("[TB] FAIL gap_period: got %0d expected %0d", c - lastValid, 2 * OSR);
          end
        end
        lastValid = c;
      end
    end
    testsRun++;
    if (firstValid != 8 * OSR) begin
      testsFailed++;
      $display("[TB] FAIL gap_first_valid: got %0d expected %0d", firstValid, 8 * OSR);
    end
  endtask

  task automatic test_reset_midframe();
    int firstValid = -1;
    apply_reset();
    for (int c = 1; c <= 5 * OSR; c++) begin
      drive_cycle(1'b1, 1'b1);
      testsRun++;
      if (valid_o !== expValid || sample_o !== expSample) begin
        testsFailed++;
        $display("[TB] FAIL midrst_pre cycle %0d: got valid=%b sample=%0d expected valid=%b sample=%0d",
                 c, valid_o, sample_o, expValid, expSample);
      end
    end
    #2 rst_n = 1'b0;
    ena = 1'b0;
    #1;
    testsRun++;
    if (sample_o !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_sample: got %0d expected 0", sample_o);
    end
    testsRun++;
    if (valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_valid: got %b expected 0", valid_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 1; c <= 4 * OSR + 8; c++) begin
      drive_cycle(1'b1, 1'b1);
      testsRun++;
      if (valid_o !== expValid || sample_o !== expSample) begin
        testsFailed++;
        $display("[TB] FAIL midrst_post cycle %0d: got valid=%b sample=%0d expected valid=%b sample=%0d",
                 c, valid_o, sample_o, expValid, expSample);
      end
      if (valid_o === 1'b1 && firstValid < 0) firstValid = c;
    end
    testsRun++;
    if (firstValid != 4 * OSR + 1) begin
      testsFailed++;
      $display("[TB] FAIL midrst_first_valid: got %0d expected %0d", firstValid, 4 * OSR + 1);
    end
  endtask

  task automatic test_random();
    int density = 50;
    apply_reset();
    for (int c = 1; c <= 1600; c++) begin
      if (c % 200 == 1) density = $urandom_range(0, 100);
      drive_cycle($urandom_range(0, 99) < density, $urandom_range(0, 3) != 0);
      testsRun++;
      if (valid_o !== expValid || sample_o !== expSample) begin
        testsFailed++;
        $display("[TB] FAIL random cycle %0d: got valid=%b sample=%0d expected valid=%b sample=%0d",
                 c, valid_o, sample_o, expValid, expSample);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_constant_ones();
    test_patterns();
    test_ena_gap();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
